// File: rtl/clip_round_stream_pkg.sv
// Shared encodings for the clip/round streaming block.
package clip_round_stream_pkg;

  typedef logic [1:0] rnd_mode_t;

  localparam rnd_mode_t RND_TRUNC  = 2'd0;
  localparam rnd_mode_t RND_HALFUP = 2'd1;
  localparam rnd_mode_t RND_CONV   = 2'd2;

endpackage

// File: rtl/round_sat_lane.sv
// One lane of the two-stage datapath: S1 rounds and shifts, S2 saturates to WIDTH_OUT.
// Stage loads are driven by the shared handshake in the top level.
module round_sat_lane
  import clip_round_stream_pkg::*;
#(
  parameter int WIDTH_IN  = 24,
  parameter int WIDTH_OUT = 16,
  parameter int CLIP_BITS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_IN-1:0]  data_i,
  input  rnd_mode_t            mode_i,
  input  logic                 ld1_i,
  input  logic                 ld2_i,
  output logic [WIDTH_OUT-1:0] data_o,
  output logic                 sat_o
);

  localparam int DROP = WIDTH_IN - CLIP_BITS - WIDTH_OUT;
  localparam int RW   = WIDTH_IN + 1 - DROP;

  logic [WIDTH_IN:0]    xe;
  logic [RW-1:0]        s1_d, s1_q;
  logic [WIDTH_OUT-1:0] s2_d, s2_q;
  logic                 sat_d, sat_q;

  assign xe = {data_i[WIDTH_IN-1], data_i};

  generate
    if (DROP == 0) begin : g_pass
      assign s1_d = xe;
    end else begin : g_round
      localparam logic [WIDTH_IN:0] HALF    = (WIDTH_IN+1)'(1) << (DROP-1);
      localparam logic [WIDTH_IN:0] HALF_M1 = HALF - (WIDTH_IN+1)'(1);
      logic [WIDTH_IN:0] rc;
      logic [WIDTH_IN:0] sum;

      always_comb begin
        rc = '0;
        case (mode_i)
          RND_HALFUP: rc = HALF;
          // Ties resolve toward the even quotient via the LSB that survives the shift.
          RND_CONV:   rc = HALF_M1 + {{WIDTH_IN{1'b0}}, data_i[DROP]};
          default:    rc = '0;
        endcase
      end

      // Cannot overflow: |x| < 2^(WIDTH_IN-1) and rc < 2^DROP <= 2^(WIDTH_IN-1).
      assign sum  = xe + rc;
      assign s1_d = RW'(sum >> DROP);
    end
  endgenerate

  // Result fits when every bit from the sign down to bit WIDTH_OUT-1 agrees.
  logic [RW-WIDTH_OUT:0] top_bits;
  logic                  ovf;

  assign top_bits = s1_q[RW-1:WIDTH_OUT-1];
  assign ovf      = !((&top_bits) || !(|top_bits));

  always_comb begin
    sat_d = ovf;
    s2_d  = s1_q[WIDTH_OUT-1:0];
    if (ovf) begin
      s2_d = s1_q[RW-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}} : {1'b0, {(WIDTH_OUT-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      sat_q <= 1'b0;
    end else begin
      if (ld1_i) begin
        s1_q <= s1_d;
      end
      if (ld2_i) begin
        s2_q  <= s2_d;
        sat_q <= sat_d;
      end
    end
  end

  assign data_o = s2_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/clip_round_stream.sv
// Multi-lane round + saturate stream, 2-cycle latency, 1 sample/clk.
// i_tready is combinational from o_tready (no skid); stalled outputs are held stable.
module clip_round_stream
  import clip_round_stream_pkg::*;
#(
  parameter int WIDTH_IN  = 24,
  parameter int WIDTH_OUT = 16,
  parameter int CLIP_BITS = 0,
  parameter int NCHAN     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       clr_stats,
  input  logic [NCHAN*WIDTH_IN-1:0]  i_tdata,
  input  logic                       i_tvalid,
  output logic                       i_tready,
  output logic [NCHAN*WIDTH_OUT-1:0] o_tdata,
  output logic [NCHAN-1:0]           o_sat,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  output logic [NCHAN*CNT_W-1:0]     sat_cnt
);

  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic ld1, ld2, o_xfer;

  assign i_tready = !s1_v_q || !s2_v_q || o_tready;
  assign ld1      = i_tvalid && i_tready;
  assign ld2      = s1_v_q && (!s2_v_q || o_tready);
  assign o_xfer   = s2_v_q && o_tready;

  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (ld1) begin
      s1_v_d = 1'b1;
    end else if (ld2) begin
      s1_v_d = 1'b0;
    end
    if (ld2) begin
      s2_v_d = 1'b1;
    end else if (o_xfer) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  assign o_tvalid = s2_v_q;

  generate
    for (genvar k = 0; k < NCHAN; k++) begin : g_lane
      logic [CNT_W-1:0] cnt_q, cnt_d;

      round_sat_lane #(
        .WIDTH_IN (WIDTH_IN),
        .WIDTH_OUT(WIDTH_OUT),
        .CLIP_BITS(CLIP_BITS)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .data_i(i_tdata[k*WIDTH_IN +: WIDTH_IN]),
        .mode_i(mode),
        .ld1_i (ld1),
        .ld2_i (ld2),
        .data_o(o_tdata[k*WIDTH_OUT +: WIDTH_OUT]),
        .sat_o (o_sat[k])
      );

      // Counter sticks at all-ones; a clear wins over a same-cycle increment.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_stats) begin
          cnt_d = '0;
        end else if (o_xfer && o_sat[k] && !(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign sat_cnt[k*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_clip_round_stream.sv
module tb_clip_round_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        clr_stats;
  logic [47:0] i_tdata;
  logic        i_tvalid;
  logic        o_tready;

  logic        rdy_a, rdy_c, rdy_n;
  logic [31:0] od_a, od_c, od_n;
  logic [1:0]  os_a, os_c, os_n;
  logic        ov_a, ov_c, ov_n;
  logic [31:0] cnt_a, cnt_c;
  logic [7:0]  cnt_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clip_round_stream dut (
    .clk(clk), .rst(rst), .mode(mode), .clr_stats(clr_stats),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(rdy_a),
    .o_tdata(od_a), .o_sat(os_a), .o_tvalid(ov_a), .o_tready(o_tready),
    .sat_cnt(cnt_a)
  );

  clip_round_stream #(.CLIP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .mode(mode), .clr_stats(clr_stats),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(rdy_c),
    .o_tdata(od_c), .o_sat(os_c), .o_tvalid(ov_c), .o_tready(o_tready),
    .sat_cnt(cnt_c)
  );

  clip_round_stream #(.CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .mode(mode), .clr_stats(clr_stats),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(rdy_n),
    .o_tdata(od_n), .o_sat(os_n), .o_tvalid(ov_n), .o_tready(o_tready),
    .sat_cnt(cnt_n)
  );

  // Reference: exact integer rounding of x / 2^drop, then clamp to int16. Returns {sat, value}.
  function automatic logic [16:0] model(input logic [23:0] x, input logic [1:0] m, input int drop);
    longint xs, q, rem, half;
    logic   sat;
    xs = longint'(signed'(x));
    q  = xs;
    if (drop > 0) begin
      q    = xs >>> drop;
      rem  = xs - (q <<< drop);
      half = longint'(1) <<< (drop - 1);
      if (m == 2'd1 && rem >= half) q = q + 1;
      if (m == 2'd2 && (rem > half || (rem == half && q[0]))) q = q + 1;
    end
    sat = 1'b0;
    if (q > 32767)  begin q = 32767;  sat = 1'b1; end
    if (q < -32768) begin q = -32768; sat = 1'b1; end
    return {sat, q[15:0]};
  endfunction

  function automatic logic [23:0] rnd_sample();
    logic [23:0] v;
    v = 24'($urandom);
    if ($urandom_range(0, 3) == 0) v[22:8] = v[23] ? 15'h0000 : 15'h7FFF;
    return v;
  endfunction

  // Push one sample into an empty pipe and capture the first output; lat = edges after acceptance.
  task automatic xfer(input logic [47:0] d, input logic [1:0] m,
                      output logic [31:0] qa, output logic [1:0] sa,
                      output logic [31:0] qc, output logic [1:0] sc, output int lat);
    i_tdata = d; mode = m; i_tvalid = 1'b1; o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    lat = -1; qa = '0; sa = '0; qc = '0; sc = '0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (ov_a) begin
        lat = i; qa = od_a; sa = os_a; qc = od_c; sc = os_c;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; clr_stats = 1'b0; i_tdata = '0; i_tvalid = 1'b0; o_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b want=0", ov_a); end
    checks++; if (od_a !== 32'h0) begin failures++; $display("FAIL reset_odata got=%h want=0", od_a); end
    checks++; if (os_a !== 2'b00) begin failures++; $display("FAIL reset_osat got=%b want=00", os_a); end
    checks++; if (cnt_a !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h want=0", cnt_a); end
    checks++; if (rdy_a !== 1'b1) begin failures++; $display("FAIL reset_itready got=%b want=1", rdy_a); end
    @(posedge clk); #1;
    checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL reset_idle_ovalid got=%b want=0", ov_a); end
  endtask

  task automatic test_rounding();
    logic [23:0] tin [3];
    logic [15:0] texp [3][3];
    logic [31:0] qa, qc;
    logic [1:0]  sa, sc;
    logic [23:0] r1;
    logic [16:0] e1;
    int lat, mm;
    tin  = '{24'h000180, 24'h000280, 24'hFFFE80};
    texp = '{'{16'h0001, 16'h0002, 16'h0002},
             '{16'h0002, 16'h0003, 16'h0002},
             '{16'hFFFE, 16'hFFFF, 16'hFFFE}};
    for (int i = 0; i < 3; i++) begin
      for (int m = 0; m < 4; m++) begin
        r1 = rnd_sample();
        mm = (m == 3) ? 0 : m;
        xfer({r1, tin[i]}, 2'(m), qa, sa, qc, sc, lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL round_latency x=%h got=%0d want=1", tin[i], lat); end
        checks++;
        if (qa[15:0] !== texp[i][mm] || sa[0] !== 1'b0) begin
          failures++;
          $display("FAIL round_lane0 x=%h mode=%0d got=%h sat=%b want=%h sat=0", tin[i], m, qa[15:0], sa[0], texp[i][mm]);
        end
        e1 = model(r1, 2'(m), 8);
        checks++;
        if ({sa[1], qa[31:16]} !== e1) begin
          failures++; $display("FAIL round_lane1 x=%h mode=%0d got=%h want=%h", r1, m, {sa[1], qa[31:16]}, e1);
        end
        e1 = model(r1, 2'(m), 6);
        checks++;
        if ({sc[1], qc[31:16]} !== e1) begin
          failures++; $display("FAIL round_clip_lane1 x=%h mode=%0d got=%h want=%h", r1, m, {sc[1], qc[31:16]}, e1);
        end
      end
    end
  endtask

  task automatic test_carry();
    logic [31:0] qa, qc;
    logic [1:0]  sa, sc;
    int lat;
    xfer({24'h000000, 24'h7FFF80}, 2'd1, qa, sa, qc, sc, lat);
    checks++;
    if (qa[15:0] !== 16'h7FFF || sa[0] !== 1'b1) begin
      failures++; $display("FAIL carry_halfup got=%h sat=%b want=7fff sat=1", qa[15:0], sa[0]);
    end
    for (int m = 0; m < 3; m++) begin
      xfer({24'h800000, 24'h800000}, 2'(m), qa, sa, qc, sc, lat);
      checks++;
      if (qa !== 32'h80008000 || sa !== 2'b00) begin
        failures++; $display("FAIL carry_minimum mode=%0d got=%h sat=%b want=80008000 sat=00", m, qa, sa);
      end
    end
  endtask

  task automatic test_clip();
    logic [31:0] qa, qc;
    logic [1:0]  sa, sc;
    int lat;
    xfer({24'hBFFFFF, 24'h400000}, 2'd0, qa, sa, qc, sc, lat);
    checks++;
    if (qc !== 32'h80007FFF || sc !== 2'b11) begin
      failures++; $display("FAIL clip_over got=%h sat=%b want=80007fff sat=11", qc, sc);
    end
    xfer({24'h000000, 24'h1FFFC0}, 2'd0, qa, sa, qc, sc, lat);
    checks++;
    if (qc[15:0] !== 16'h7FFF || sc[0] !== 1'b0) begin
      failures++; $display("FAIL clip_edge got=%h sat=%b want=7fff sat=0", qc[15:0], sc[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] b0 [10];
    logic [23:0] b1 [10];
    logic [1:0]  bm [10];
    logic [16:0] e0, e1;
    for (int i = 0; i < 10; i++) begin
      b0[i] = rnd_sample(); b1[i] = rnd_sample(); bm[i] = 2'($urandom_range(0, 3));
    end
    o_tready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      i_tvalid = (c < 10);
      if (c < 10) begin i_tdata = {b1[c], b0[c]}; mode = bm[c]; end
      #1;
      if (c < 10) begin
        checks++;
        if (rdy_a !== 1'b1) begin failures++; $display("FAIL b2b_itready cycle=%0d got=%b want=1", c, rdy_a); end
      end
      if (c < 2 || c > 11) begin
        checks++;
        if (ov_a !== 1'b0) begin failures++; $display("FAIL b2b_idle cycle=%0d got=%b want=0", c, ov_a); end
      end else begin
        e0 = model(b0[c-2], bm[c-2], 8);
        e1 = model(b1[c-2], bm[c-2], 8);
        checks++;
        if (ov_a !== 1'b1 || {os_a[1], od_a[31:16], os_a[0], od_a[15:0]} !== {e1, e0}) begin
          failures++;
          $display("FAIL b2b_data cycle=%0d got=v%b %h want=v1 %h", c, ov_a,
                   {os_a[1], od_a[31:16], os_a[0], od_a[15:0]}, {e1, e0});
        end
      end
    end
    i_tvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [33:0] qa_q [$];
    logic [33:0] qc_q [$];
    logic [33:0] exp_a, exp_c;
    logic [31:0] held_d;
    logic [1:0]  held_s;
    logic [23:0] x0, x1;
    logic        stall_prev;
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; held_d = '0; held_s = '0;
    while (rcvd < 100 && cyc < 3000) begin
      @(posedge clk); #1;
      x0 = rnd_sample(); x1 = rnd_sample();
      i_tdata  = {x1, x0};
      mode     = 2'($urandom_range(0, 3));
      i_tvalid = (sent < 100) && ($urandom_range(0, 1) == 1);
      o_tready = ($urandom_range(0, 1) == 1);
      #1;
      if (stall_prev) begin
        checks++;
        if (ov_a !== 1'b1 || od_a !== held_d || os_a !== held_s) begin
          failures++; $display("FAIL stall_hold cycle=%0d got=v%b %h/%b want=v1 %h/%b", cyc, ov_a, od_a, os_a, held_d, held_s);
        end
      end
      if (i_tvalid && rdy_a) begin
        qa_q.push_back({model(x1, mode, 8), model(x0, mode, 8)});
        qc_q.push_back({model(x1, mode, 6), model(x0, mode, 6)});
        sent++;
      end
      if (ov_a && o_tready) begin
        checks++;
        if (qa_q.size() == 0) begin
          failures++; $display("FAIL bp_extra_output got=%h want=none", od_a);
        end else begin
          exp_a = qa_q.pop_front();
          exp_c = qc_q.pop_front();
          if ({os_a[1], od_a[31:16], os_a[0], od_a[15:0]} !== exp_a ||
              {os_c[1], od_c[31:16], os_c[0], od_c[15:0]} !== exp_c) begin
            failures++;
            $display("FAIL bp_data n=%0d got=%h/%h want=%h/%h", rcvd,
                     {os_a[1], od_a[31:16], os_a[0], od_a[15:0]},
                     {os_c[1], od_c[31:16], os_c[0], od_c[15:0]}, exp_a, exp_c);
          end
        end
        rcvd++;
      end
      stall_prev = ov_a && !o_tready;
      held_d = od_a; held_s = os_a;
      cyc++;
    end
    checks++;
    if (rcvd != 100) begin failures++; $display("FAIL bp_timeout got=%0d want=100", rcvd); end
    @(posedge clk); #1;
    i_tvalid = 1'b0; o_tready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_counters();
    logic [31:0] qa, qc;
    logic [1:0]  sa, sc;
    int lat;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    checks++;
    if (cnt_a !== 32'h0) begin failures++; $display("FAIL cnt_clear got=%h want=0", cnt_a); end
    for (int i = 0; i < 3; i++) xfer({24'h7FFF80, 24'h000100}, 2'd1, qa, sa, qc, sc, lat);
    checks++;
    if (cnt_a !== 32'h00030000) begin failures++; $display("FAIL cnt_three got=%h want=00030000", cnt_a); end
    checks++;
    if (cnt_n !== 8'h30) begin failures++; $display("FAIL cnt_three_w4 got=%h want=30", cnt_n); end
    i_tdata = {24'h7FFF80, 24'h000100}; mode = 2'd1; i_tvalid = 1'b1; o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov_a !== 1'b1 || os_a !== 2'b10) begin failures++; $display("FAIL cnt_clr_setup got=v%b s%b want=v1 s10", ov_a, os_a); end
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    checks++;
    if (cnt_a !== 32'h0 || cnt_n !== 8'h0) begin
      failures++; $display("FAIL cnt_clr_priority got=%h/%h want=0/0", cnt_a, cnt_n);
    end
    for (int i = 0; i < 20; i++) xfer({24'h7FFF80, 24'h000100}, 2'd1, qa, sa, qc, sc, lat);
    checks++;
    if (cnt_n !== 8'hF0) begin failures++; $display("FAIL cnt_saturate_w4 got=%h want=f0", cnt_n); end
    checks++;
    if (cnt_a !== 32'h00140000) begin failures++; $display("FAIL cnt_twenty got=%h want=00140000", cnt_a); end
  endtask

  task automatic test_reset_midstream();
    logic stale;
    o_tready = 1'b0;
    @(posedge clk); #1;
    i_tdata = {24'h7FFF80, 24'h400000}; mode = 2'd1; i_tvalid = 1'b1;
    @(posedge clk); #1;
    i_tdata = {24'h123456, 24'h7FFF80};
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    checks++;
    if (ov_a !== 1'b1 || rdy_a !== 1'b0) begin
      failures++; $display("FAIL rst_mid_setup got=v%b r%b want=v1 r0", ov_a, rdy_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov_a !== 1'b0 || rdy_a !== 1'b1 || cnt_a !== 32'h0 || cnt_n !== 8'h0 || od_a !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_flush got=v%b r%b cnt=%h/%h d=%h want=v0 r1 cnt=0/0 d=0", ov_a, rdy_a, cnt_a, cnt_n, od_a);
    end
    rst = 1'b0; o_tready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ov_a !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin failures++; $display("FAIL rst_mid_stale got=output want=none"); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_carry();
    test_clip();
    test_back_to_back();
    test_backpressure();
    test_counters();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
